tt_sweep_driver: RTL

TT_SWEEP_DRIVER -- requirements
Module: tt_sweep_driver

---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/tt_sweep_driver_timer.sv | 35 +++
 rtl/tt_sweep_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep driver.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int unsigned N_VEC = 8;
    localparam int unsigned X_W   = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [N_VEC-1:0] DEFAULT_TABLE = 8'b00111001;

endpackage

// File: rtl/tt_sweep_driver_timer.sv
// Settle counter: counts enabled cycles, flags the last settle cycle.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/tt_sweep_driver.sv
// Drives all 3-bit vectors to a downstream stage and records its error flag per vector.
// Optional TT_SWEEP_CAPTURE_EN adds obs_table/table_mismatch capture of z_in.
module tt_sweep_driver
    import tt_sweep_pkg::*;
#(
    parameter int unsigned      SETTLE_CYC = 2,
    parameter logic [N_VEC-1:0] EXPECTED   = DEFAULT_TABLE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             err_in,
    input  logic             z_in,
    output logic [X_W-1:0]   x,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] fail_mask,
    output logic [CNT_W-1:0] fail_count
`ifdef TT_SWEEP_CAPTURE_EN
    ,
    output logic [N_VEC-1:0] obs_table,
    output logic             table_mismatch
`endif
);

    sweep_state_t     state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [N_VEC-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             done_q, done_d;
    logic             tmr_clear, tmr_enable, tmr_expired;

`ifdef TT_SWEEP_CAPTURE_EN
    logic [N_VEC-1:0] obs_q, obs_d;
`else
    logic unused_z;
    assign unused_z = z_in;
`endif

    tt_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        mask_d     = mask_q;
        fcnt_d     = fcnt_q;
        done_d     = done_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
`ifdef TT_SWEEP_CAPTURE_EN
        obs_d      = obs_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    x_d       = '0;
                    mask_d    = '0;
                    fcnt_d    = '0;
                    done_d    = 1'b0;
                    tmr_clear = 1'b1;
`ifdef TT_SWEEP_CAPTURE_EN
                    obs_d     = '0;
`endif
                end
            end
            SETTLE: begin
                tmr_enable = 1'b1;
                if (tmr_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                mask_d[x_q] = err_in;
                fcnt_d      = fcnt_q + CNT_W'(err_in);
`ifdef TT_SWEEP_CAPTURE_EN
                obs_d[x_q]  = z_in;
`endif
                // Last vector: stop at 7 rather than wrapping.
                if (x_q == X_W'(N_VEC - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    x_d       = x_q + X_W'(1);
                    tmr_clear = 1'b1;
                    state_d   = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            mask_q  <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
`ifdef TT_SWEEP_CAPTURE_EN
            obs_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            mask_q  <= mask_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
`ifdef TT_SWEEP_CAPTURE_EN
            obs_q   <= obs_d;
`endif
        end
    end

    assign x          = x_q;
    assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done       = done_q;
    assign pass       = done_q && (fcnt_q == '0);
    assign fail_mask  = mask_q;
    assign fail_count = fcnt_q;

`ifdef TT_SWEEP_CAPTURE_EN
    assign obs_table      = obs_q;
    assign table_mismatch = done_q && (obs_q != EXPECTED);
`endif

endmodule
